// File: rtl/multi_sprite_bouncer_pkg.sv
// rtl/multi_sprite_bouncer_pkg.sv - shared types, screen defaults and colour helper for the sprite bouncer
package multi_sprite_bouncer_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef logic [2:0] colour_t;

  typedef enum logic {
    IDLE,
    UPDATE
  } fsm_state_t;

  // Colour 0 would render black-on-black, so the cycle runs 1..7 and wraps to 1.
  function automatic colour_t next_colour(input colour_t c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

endpackage

// File: rtl/multi_sprite_bouncer_if.sv
// rtl/multi_sprite_bouncer_if.sv - video timing in, frame control in, busy and pixel colour out
interface multi_sprite_bouncer_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
) ();

  logic           frame_tick;
  logic           pause;
  logic           visible;
  logic [X_W-1:0] position_x;
  logic [Y_W-1:0] position_y;
  logic           busy;
  logic [3:0]     r;
  logic [3:0]     g;
  logic [3:0]     b;

  modport master (
    output frame_tick, pause, visible, position_x, position_y,
    input  busy, r, g, b
  );

  modport slave (
    input  frame_tick, pause, visible, position_x, position_y,
    output busy, r, g, b
  );

endinterface

// File: rtl/multi_sprite_bouncer_sprite_axis_step.sv
// rtl/multi_sprite_bouncer_sprite_axis_step.sv - one-axis motion step with edge reflection
module multi_sprite_bouncer_sprite_axis_step #(
  parameter int POS_W = 10,
  parameter int VEL_W = 4,
  parameter int LIMIT = 576
) (
  input  logic        [POS_W-1:0] pos_i,
  input  logic signed [VEL_W-1:0] vel_i,
  output logic        [POS_W-1:0] pos_o,
  output logic signed [VEL_W-1:0] vel_o,
  output logic                    bounce_o
);

  // Two guard bits: one for the sign, one so pos + vel past LIMIT cannot wrap.
  localparam int TW = POS_W + 2;
  localparam logic signed [TW-1:0] LIM = TW'(LIMIT);

  logic signed [TW-1:0] traj;

  always_comb begin
    traj     = $signed({2'b00, pos_i}) + $signed({{(TW-VEL_W){vel_i[VEL_W-1]}}, vel_i});
    pos_o    = pos_i;
    vel_o    = vel_i;
    bounce_o = 1'b0;
    if (traj < 0) begin
      pos_o    = '0;
      vel_o    = -vel_i;
      bounce_o = 1'b1;
    end else if (traj > LIM) begin
      pos_o    = POS_W'(LIMIT);
      vel_o    = -vel_i;
      bounce_o = 1'b1;
    end else begin
      pos_o    = traj[POS_W-1:0];
    end
  end

endmodule

// File: rtl/multi_sprite_bouncer.sv
// rtl/multi_sprite_bouncer.sv - NUM_SPRITES bouncing boxes: shared once-per-frame motion update and
// fixed-priority compositor with registered RGB output
module multi_sprite_bouncer
  import multi_sprite_bouncer_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int NUM_SPRITES = 4,
  parameter int BOX_W       = 64,
  parameter int BOX_H       = 48,
  parameter int VEL_W       = 4,
  parameter int BG_LEVEL    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_sprite_bouncer_if.slave vid
);

  localparam int XW   = $clog2(SCREEN_W);
  localparam int YW   = $clog2(SCREEN_H);
  localparam int XLIM = SCREEN_W - BOX_W;
  localparam int YLIM = SCREEN_H - BOX_H;
  localparam int IW   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  logic        [XW-1:0]    x_q   [NUM_SPRITES];
  logic        [YW-1:0]    y_q   [NUM_SPRITES];
  logic signed [VEL_W-1:0] vx_q  [NUM_SPRITES];
  logic signed [VEL_W-1:0] vy_q  [NUM_SPRITES];
  colour_t                 col_q [NUM_SPRITES];

  fsm_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  logic        [XW-1:0]    x_d;
  logic        [YW-1:0]    y_d;
  logic signed [VEL_W-1:0] vx_d;
  logic signed [VEL_W-1:0] vy_d;
  colour_t                 col_d;
  logic                    bounce_x, bounce_y;

  logic [XW:0] px;
  logic [YW:0] py;
  logic        hit_any;
  colour_t     hit_col;
  logic [3:0]  r_q, g_q, b_q, r_d, g_d, b_d;

  function automatic logic [XW-1:0] reset_x(input int i);
    int v;
    v = 32 + i * 96;
    if (v > XLIM) v = XLIM;
    return XW'(v);
  endfunction

  function automatic logic [YW-1:0] reset_y(input int i);
    int v;
    v = 24 + i * 64;
    if (v > YLIM) v = YLIM;
    return YW'(v);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // frame_tick is only looked at in IDLE, so ticks during an update are dropped, not queued.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (vid.frame_tick && !vid.pause) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        if (idx_q == IW'(NUM_SPRITES - 1)) state_d = IDLE;
        else                               idx_d   = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  multi_sprite_bouncer_sprite_axis_step #(
    .POS_W (XW),
    .VEL_W (VEL_W),
    .LIMIT (XLIM)
  ) u_step_x (
    .pos_i    (x_q[idx_q]),
    .vel_i    (vx_q[idx_q]),
    .pos_o    (x_d),
    .vel_o    (vx_d),
    .bounce_o (bounce_x)
  );

  multi_sprite_bouncer_sprite_axis_step #(
    .POS_W (YW),
    .VEL_W (VEL_W),
    .LIMIT (YLIM)
  ) u_step_y (
    .pos_i    (y_q[idx_q]),
    .vel_i    (vy_q[idx_q]),
    .pos_o    (y_d),
    .vel_o    (vy_d),
    .bounce_o (bounce_y)
  );

  // A corner hit bounces both axes but still advances the colour only once.
  assign col_d = (bounce_x || bounce_y) ? next_colour(col_q[idx_q]) : col_q[idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i]   <= reset_x(i);
        y_q[i]   <= reset_y(i);
        vx_q[i]  <= VEL_W'((i % 2 == 0) ? 2 : -2);
        vy_q[i]  <= VEL_W'((i % 2 == 1) ? 1 : -1);
        col_q[i] <= colour_t'((i % 7) + 1);
      end
    end else if (state_q == UPDATE) begin
      x_q[idx_q]   <= x_d;
      y_q[idx_q]   <= y_d;
      vx_q[idx_q]  <= vx_d;
      vy_q[idx_q]  <= vy_d;
      col_q[idx_q] <= col_d;
    end
  end

  assign px = {1'b0, vid.position_x};
  assign py = {1'b0, vid.position_y};

  // Walk from the highest index down so the lowest-index hit is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_col = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (px >= {1'b0, x_q[i]} && px < {1'b0, x_q[i]} + (XW+1)'(BOX_W) &&
          py >= {1'b0, y_q[i]} && py < {1'b0, y_q[i]} + (YW+1)'(BOX_H)) begin
        hit_any = 1'b1;
        hit_col = col_q[i];
      end
    end
  end

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (vid.visible) begin
      if (hit_any) begin
        r_d = {4{hit_col[0]}};
        g_d = {4{hit_col[1]}};
        b_d = {4{hit_col[2]}};
      end else begin
        r_d = 4'(BG_LEVEL);
        g_d = 4'(BG_LEVEL);
        b_d = 4'(BG_LEVEL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign vid.busy = (state_q == UPDATE);
  assign vid.r    = r_q;
  assign vid.g    = g_q;
  assign vid.b    = b_q;

endmodule
